// File: rtl/axis_fadd_collect.sv
// Result collector for a ready-less fp32 adder stream: credit-gated issue plus a FWFT result FIFO.
// Optional AXIS_FADD_COLLECT_PKT_CNT_EN adds PKT_CNT, a count of popped TLAST beats.
module axis_fadd_collect #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IN_TDATA,
  input  logic        IN_TLAST,
  input  logic        IN_TVALID,
  input  logic        ISSUE,
  output logic        ISSUE_OK,
  output logic [31:0] OUT_TDATA,
  output logic        OUT_TLAST,
  output logic        OUT_TVALID,
  input  logic        OUT_TREADY,
`ifdef AXIS_FADD_COLLECT_PKT_CNT_EN
  output logic [15:0] PKT_CNT,
`endif
  output logic        OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem_data [DEPTH];
  logic          mem_last [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic [CW-1:0] crd;
  logic          pop;
  logic          push;
  logic          crd_inc;
  logic          crd_dec;

  assign OUT_TVALID = (occ != '0);
  assign OUT_TDATA  = mem_data[rd_ptr];
  assign OUT_TLAST  = mem_last[rd_ptr];
  assign pop        = OUT_TVALID && OUT_TREADY;
  // A full FIFO can still take a beat when the head leaves in the same cycle.
  assign push       = IN_TVALID && ((occ != FULL) || pop);
  assign crd_inc    = ISSUE && (crd != FULL);
  assign crd_dec    = pop && (crd != '0);
  assign ISSUE_OK   = !rst && (crd < FULL);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= IN_TDATA;
      mem_last[wr_ptr] <= IN_TLAST;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      crd      <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (push && !pop)      occ <= occ + CW'(1);
      else if (pop && !push) occ <= occ - CW'(1);

      if (crd_inc && !crd_dec)      crd <= crd + CW'(1);
      else if (crd_dec && !crd_inc) crd <= crd - CW'(1);

      // Sticky: dropped beat, issue past the credit limit, or pop with no credit.
      if ((IN_TVALID && !push) || (ISSUE && crd == FULL) || (pop && crd == '0))
        OVERFLOW <= 1'b1;
    end
  end

`ifdef AXIS_FADD_COLLECT_PKT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   PKT_CNT <= '0;
    else if (pop && OUT_TLAST) PKT_CNT <= PKT_CNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_axis_fadd_collect.sv
// Directed self-checking bench for axis_fadd_collect (DEPTH=16).
module tb_axis_fadd_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IN_TDATA;
  logic        IN_TLAST;
  logic        IN_TVALID;
  logic        ISSUE;
  logic        ISSUE_OK;
  logic [31:0] OUT_TDATA;
  logic        OUT_TLAST;
  logic        OUT_TVALID;
  logic        OUT_TREADY;
  logic        OVERFLOW;
`ifdef AXIS_FADD_COLLECT_PKT_CNT_EN
  logic [15:0] PKT_CNT;
`endif

  int n_run  = 0;
  int n_fail = 0;

  axis_fadd_collect #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .IN_TDATA   (IN_TDATA),
    .IN_TLAST   (IN_TLAST),
    .IN_TVALID  (IN_TVALID),
    .ISSUE      (ISSUE),
    .ISSUE_OK   (ISSUE_OK),
    .OUT_TDATA  (OUT_TDATA),
    .OUT_TLAST  (OUT_TLAST),
    .OUT_TVALID (OUT_TVALID),
    .OUT_TREADY (OUT_TREADY),
`ifdef AXIS_FADD_COLLECT_PKT_CNT_EN
    .PKT_CNT    (PKT_CNT),
`endif
    .OVERFLOW   (OVERFLOW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] held;
  logic        stalled;
  int          rx;

  initial begin
    rst = 1'b1; IN_TDATA = '0; IN_TLAST = 1'b0; IN_TVALID = 1'b0;
    ISSUE = 1'b0; OUT_TREADY = 1'b0;
    step();
    chk("rst_issue_ok", 32'(ISSUE_OK), 32'd0);
    chk("rst_out_valid", 32'(OUT_TVALID), 32'd0);
    chk("rst_crd", 32'(dut.crd), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_issue_ok", 32'(ISSUE_OK), 32'd1);

    // In-order pass-through
    OUT_TREADY = 1'b1;
    ISSUE = 1'b1;
    repeat (3) step();
    ISSUE = 1'b0;
    chk("pt_crd3", 32'(dut.crd), 32'd3);
    IN_TVALID = 1'b1; IN_TDATA = 32'h3F80_0000; IN_TLAST = 1'b0;
    chk("pt_no_bypass", 32'(OUT_TVALID), 32'd0);
    step();
    chk("pt_v1", 32'(OUT_TVALID), 32'd1);
    chk("pt_d1", OUT_TDATA, 32'h3F80_0000);
    chk("pt_l1", 32'(OUT_TLAST), 32'd0);
    IN_TDATA = 32'h4000_0000;
    step();
    chk("pt_d2", OUT_TDATA, 32'h4000_0000);
    chk("pt_l2", 32'(OUT_TLAST), 32'd0);
    IN_TDATA = 32'h4040_0000; IN_TLAST = 1'b1;
    step();
    chk("pt_d3", OUT_TDATA, 32'h4040_0000);
    chk("pt_l3", 32'(OUT_TLAST), 32'd1);
    IN_TVALID = 1'b0; IN_TLAST = 1'b0;
    step();
    chk("pt_empty", 32'(OUT_TVALID), 32'd0);
    chk("pt_crd0", 32'(dut.crd), 32'd0);
`ifdef AXIS_FADD_COLLECT_PKT_CNT_EN
    chk("pt_pkt_cnt", 32'(PKT_CNT), 32'd1);
`endif

    // Credit fill and full FIFO
    OUT_TREADY = 1'b0;
    ISSUE = 1'b1;
    repeat (15) step();
    chk("fill_ok15", 32'(ISSUE_OK), 32'd1);
    step();
    ISSUE = 1'b0;
    chk("fill_ok16", 32'(ISSUE_OK), 32'd0);
    chk("fill_crd16", 32'(dut.crd), 32'd16);
    IN_TVALID = 1'b1;
    for (int i = 0; i < 16; i++) begin
      IN_TDATA = 32'h100 + 32'(i);
      step();
    end
    IN_TVALID = 1'b0;
    chk("fill_occ16", 32'(dut.occ), 32'd16);
    chk("fill_head", OUT_TDATA, 32'h100);

    // Push and pop together while full
    IN_TVALID = 1'b1; IN_TDATA = 32'h200; OUT_TREADY = 1'b1;
    step();
    IN_TVALID = 1'b0; OUT_TREADY = 1'b0;
    chk("fullpp_occ", 32'(dut.occ), 32'd16);
    chk("fullpp_ovf", 32'(OVERFLOW), 32'd0);
    chk("fullpp_head", OUT_TDATA, 32'h101);
    chk("fullpp_issue_ok", 32'(ISSUE_OK), 32'd1);
    ISSUE = 1'b1;
    step();
    chk("refill_crd16", 32'(dut.crd), 32'd16);

    // Violations: issue at full credit, beat into full FIFO without pop
    step();
    ISSUE = 1'b0;
    chk("viol_crd_sat", 32'(dut.crd), 32'd16);
    chk("viol_ovf", 32'(OVERFLOW), 32'd1);
    IN_TVALID = 1'b1; IN_TDATA = 32'hDEAD_BEEF;
    step();
    IN_TVALID = 1'b0;
    chk("viol_occ", 32'(dut.occ), 32'd16);
    step();
    chk("viol_ovf_sticky", 32'(OVERFLOW), 32'd1);
    OUT_TREADY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), OUT_TDATA, (i < 15) ? 32'h101 + 32'(i) : 32'h200);
      step();
    end
    OUT_TREADY = 1'b0;
    chk("drain_empty", 32'(OUT_TVALID), 32'd0);
    chk("drain_crd0", 32'(dut.crd), 32'd0);

    // Backpressure 1010..., beats arrive with no credit taken (pops at CRD=0)
    do_reset();
    for (int i = 0; i < 20; i++) exp_q.push_back(32'h300 + 32'(i));
    rx = 0;
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 60 && rx < 20; c++) begin
      IN_TVALID  = (c < 20);
      IN_TDATA   = 32'h300 + 32'(c);
      OUT_TREADY = (c % 2 == 0);
      if (stalled) chk("bp_stable", OUT_TDATA, held);
      stalled = OUT_TVALID && !OUT_TREADY;
      held = OUT_TDATA;
      if (OUT_TVALID && OUT_TREADY) begin
        chk($sformatf("bp_beat_%0d", rx), OUT_TDATA, exp_q[rx]);
        rx++;
      end
      step();
    end
    IN_TVALID = 1'b0; OUT_TREADY = 1'b0;
    chk("bp_count", 32'(rx), 32'd20);
    chk("bp_empty", 32'(OUT_TVALID), 32'd0);
    chk("bp_crd_floor", 32'(dut.crd), 32'd0);
    chk("bp_ovf_underflow", 32'(OVERFLOW), 32'd1);

    // Reset mid-operation with OCC=5, CRD=9
    do_reset();
    ISSUE = 1'b1;
    repeat (9) step();
    ISSUE = 1'b0;
    IN_TVALID = 1'b1; IN_TLAST = 1'b1;
    repeat (5) step();
    IN_TVALID = 1'b0; IN_TLAST = 1'b0;
    chk("mid_occ5", 32'(dut.occ), 32'd5);
    chk("mid_crd9", 32'(dut.crd), 32'd9);
    rst = 1'b1;
    #1;
    chk("mid_async_valid", 32'(OUT_TVALID), 32'd0);
    chk("mid_async_issue_ok", 32'(ISSUE_OK), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_valid", 32'(OUT_TVALID), 32'd0);
    chk("mid_crd", 32'(dut.crd), 32'd0);
    chk("mid_ovf", 32'(OVERFLOW), 32'd0);
    chk("mid_issue_ok", 32'(ISSUE_OK), 32'd1);
`ifdef AXIS_FADD_COLLECT_PKT_CNT_EN
    chk("mid_pkt_cnt", 32'(PKT_CNT), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
